dnn_fc_layer_fix: RTL and testbench
===================================

# dnn_fc_layer_fix

Parametrised fixed-point fully-connected layer engine with LUT sigmoid and argmax classification. It streams activations, weights and sigmoid LUT entries through a single synchronous read port, computes `N_OUT` neurons of `N_IN` inputs plus bias, and registers all outputs. It also reports the winning class index. It replaces the fixed 400x10 / 12-bit inference core and is the building block for multi-layer and wider-format networks.

## Interface
- `DATA_WIDTH`, 12: signed word width of activations, weights, LUT entries and outputs.
- `FRAC_BITS`, 10: fractional bits of the fixed-point format.
- `ADDR_WIDTH`, 16: memory address width.
- `N_IN`, 400: inputs per neuron, excluding bias.
- `N_OUT`, 10: neuron and output count.
- `ACC_WIDTH`, 32: accumulator width; must be ≥ 2*DATA_WIDTH+$clog2(N_IN+1).
- `ADDR_BASE_A`, 16'h0000: base address of activation `a[i]`.
- `ADDR_BASE_W`, 16'h0191: base of weights; `w[j][i]` is at `ADDR_BASE_W + j*(N_IN+1) + i`, and `i=N_IN` is the bias weight.
- `ADDR_BASE_LUT`, 16'h29be: base of the 2^DATA_WIDTH-entry sigmoid LUT.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: begin inference; sampled only in IDLE or DONE.
- `clear`  in  1: synchronous soft clear, active-high.
- `mem_data`  in  DATA_WIDTH signed: read data, valid the cycle after `mem_addr`.
- `mem_addr`  out  ADDR_WIDTH: read address, combinational from state and counters.
- `done`  out  1: results valid; level signal.
- `out[N_OUT-1:0]`  out  DATA_WIDTH signed each: sigmoid outputs.
- `class_idx`  out  $clog2(N_OUT): index of the maximum output.

## Operation
- States: IDLE, MAC, DRAIN, LUT, WRITE, DONE.
- Counters: neuron `j` (0..N_OUT-1), term `i` (0..N_IN), phase `p` (0 = A slot, 1 = W slot).
- IDLE: `mem_addr`=ADDR_BASE_A. On `start`, go to MAC with `j`=0, `i`=0, `p`=0, and the accumulator cleared.
- MAC, p=0: `mem_addr`=ADDR_BASE_A+i. The W data from the previous term is accumulated.
- MAC, p=1: `mem_addr`=ADDR_BASE_W+j*(N_IN+1)+i. `a` is latched from `mem_data`. For `i`=N_IN, `a` is forced to ONE=2^FRAC_BITS and the data read is ignored.
- Accumulate: acc += (a*w) >>> FRAC_BITS. The product is a full 2*DATA_WIDTH signed value; the shift is arithmetic (floor).
- MAC lasts 2*(N_IN+1) cycles, then DRAIN. In DRAIN, the last bias product is accumulated.
- LUT: `s` = acc saturated to the signed DATA_WIDTH range [-2^(DW-1), 2^(DW-1)-1]. `mem_addr`=ADDR_BASE_LUT + (s with MSB inverted).
- WRITE: `out[j]` <= `mem_data`. Argmax update:
  - If `j`==0, or `mem_data` is strictly greater than the running max, then max <= `mem_data` and `class_idx` <= j.
  - Ties keep the lower index.
- After WRITE: if `j`<N_OUT-1, then `j`++, the accumulator clears and the next state is MAC; otherwise the next state is DONE.
- DONE: `done`=1, and `out` and `class_idx` hold. `start` re-launches: state goes to MAC and `done` drops on the next cycle. `out` is overwritten progressively.
- `start` while in MAC, DRAIN, LUT or WRITE is ignored.
- `rst`=0 or `clear`=1 at any edge, including mid-inference:
  - State goes to IDLE and all counters, the accumulator and the running max are zeroed.
  - All `out`=0, `class_idx`=0, `done`=0.
  - `rst` has priority over `clear`; `clear` has priority over `start`.

## Timing
- Reset values: `done`=0, `out[*]`=0, `class_idx`=0, `mem_addr`=ADDR_BASE_A.
- Memory read latency is exactly 1 cycle. There is no stall or handshake on the memory port.
- Per neuron: 2*(N_IN+1)+3 cycles (MAC + DRAIN + LUT + WRITE).
- `done` rises exactly N_OUT*(2*N_IN+5) rising edges after the edge that samples `start`.
- `out[j]` is updated at the end of neuron `j`'s WRITE cycle and is stable thereafter until the next run or clear.
- `class_idx` is final when `done` rises.

## Test plan
Common setup: `DATA_WIDTH`=12, `FRAC_BITS`=10, `N_IN`=2, `N_OUT`=3. The LUT is loaded as identity, so `LUT[k]`=k-2048. Activations: `a`=(512, 1024).
- Basic run:
  - Stimulus: w0=(1024,1024,0), w1=(2047,2047,2047), w2=(-2048,-2048,-2048); pulse `start`.
  - Response: `done` rises after 27 cycles. `out`=(1536, 2047, -2048), with neuron 1 positively saturated (raw 5117) and neuron 2 negatively saturated (raw -5120). `class_idx`=1.
- Address trace: monitor `mem_addr` for neuron 1.
  - Required sequence: 0, 0x194, 1, 0x195, 2, 0x196, then the LUT address.
  - For neuron 0, the LUT address is 0x29be+0xE00.
- Tie:
  - Stimulus: all weights = (1024,0,0).
  - Response: `out`=(512,512,512) and `class_idx`=0.
- Floor rounding:
  - Stimulus: a=(1,0), w0=(-1,0,0).
  - Response: `out[0]`=-1, since (-1)>>>10 = -1.
- Mid-run abort:
  - Stimulus: assert `clear` in cycle 10, then start again.
  - Response: the next cycle shows IDLE with `out`=0 and `done`=0; a fresh run then yields the basic-run results.
  - Repeat with `rst`=0 in place of `clear`; the response is identical.
- Start handling:
  - Stimulus: `start` held high for the whole run.
  - Response: restarts occur only from DONE; `done` is high for exactly 1 cycle between runs, and the results are identical on each run.

Source files
------------

// File: rtl/dnn_fc_layer_fix.sv
// rtl/dnn_fc_layer_fix.sv - fixed-point fully-connected layer with LUT sigmoid and argmax
// One shared read port: activations and weights interleave in MAC, then one LUT read per neuron.
module dnn_fc_layer_fix #(
  parameter int                  DATA_WIDTH    = 12,
  parameter int                  FRAC_BITS     = 10,
  parameter int                  ADDR_WIDTH    = 16,
  parameter int                  N_IN          = 400,
  parameter int                  N_OUT         = 10,
  parameter int                  ACC_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A   = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W   = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT = 16'h29be
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  output logic        [ADDR_WIDTH-1:0] mem_addr,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] out [N_OUT],
  output logic  [$clog2(N_OUT)-1:0]    class_idx
);

  localparam int CW = $clog2(N_OUT);
  localparam int IW = $clog2(N_IN + 1);
  localparam int PW = 2 * DATA_WIDTH + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_LUT   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // r_a carries one extra bit so the bias activation 2^FRAC_BITS always fits.
  localparam logic signed [DATA_WIDTH:0]   ONE     = (DATA_WIDTH + 1)'(1 << FRAC_BITS);
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN = ~SAT_MAX;

  logic [2:0]                      r_state;
  logic [CW-1:0]                   r_j;
  logic [IW-1:0]                   r_i;
  logic                            r_p;
  logic signed [DATA_WIDTH:0]      r_a;
  logic signed [ACC_WIDTH-1:0]     r_acc;
  logic signed [DATA_WIDTH-1:0]    r_max;
  logic signed [DATA_WIDTH-1:0]    r_out [N_OUT];
  logic [CW-1:0]                   r_class;
  logic                            r_done;

  logic signed [PW-1:0]            w_prod;
  logic signed [ACC_WIDTH-1:0]     w_term;
  logic signed [DATA_WIDTH-1:0]    w_sat;
  logic [DATA_WIDTH-1:0]           w_lut_off;
  logic [ADDR_WIDTH-1:0]           w_addr;

  assign w_prod    = r_a * mem_data;
  assign w_term    = ACC_WIDTH'(w_prod >>> FRAC_BITS);
  assign w_lut_off = {~w_sat[DATA_WIDTH-1], w_sat[DATA_WIDTH-2:0]};

  always_comb begin
    w_sat = r_acc[DATA_WIDTH-1:0];
    if (r_acc > SAT_MAX) begin
      w_sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (r_acc < SAT_MIN) begin
      w_sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
  end

  always_comb begin
    w_addr = ADDR_BASE_A;
    case (r_state)
      S_MAC: begin
        if (!r_p) begin
          w_addr = ADDR_BASE_A + ADDR_WIDTH'(r_i);
        end else begin
          w_addr = ADDR_BASE_W + ADDR_WIDTH'(r_j * (N_IN + 1)) + ADDR_WIDTH'(r_i);
        end
      end
      S_LUT:   w_addr = ADDR_BASE_LUT + ADDR_WIDTH'(w_lut_off);
      default: w_addr = ADDR_BASE_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_i     <= '0;
      r_p     <= 1'b0;
      r_a     <= '0;
      r_acc   <= '0;
      r_max   <= '0;
      r_class <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_MAC;
            r_j     <= '0;
            r_i     <= '0;
            r_p     <= 1'b0;
            r_acc   <= '0;
          end
        end
        S_MAC: begin
          if (!r_p) begin
            // mem_data holds the weight fetched for term i-1
            if (r_i != '0) r_acc <= r_acc + w_term;
            r_p <= 1'b1;
          end else begin
            r_a <= (r_i == IW'(N_IN)) ? ONE : (DATA_WIDTH + 1)'(mem_data);
            r_p <= 1'b0;
            if (r_i == IW'(N_IN)) begin
              r_state <= S_DRAIN;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          r_acc   <= r_acc + w_term;
          r_state <= S_LUT;
        end
        S_LUT: r_state <= S_WRITE;
        S_WRITE: begin
          r_out[r_j] <= mem_data;
          if (r_j == '0 || mem_data > r_max) begin
            r_max   <= mem_data;
            r_class <= r_j;
          end
          if (r_j != CW'(N_OUT - 1)) begin
            r_j     <= r_j + 1'b1;
            r_i     <= '0;
            r_p     <= 1'b0;
            r_acc   <= '0;
            r_state <= S_MAC;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_MAC;
            r_j     <= '0;
            r_i     <= '0;
            r_p     <= 1'b0;
            r_acc   <= '0;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = w_addr;
  assign done      = r_done;
  assign out       = r_out;
  assign class_idx = r_class;

endmodule

// File: tb/tb_dnn_fc_layer_fix.sv
// tb/tb_dnn_fc_layer_fix.sv - table and scoreboard bench for dnn_fc_layer_fix (N_IN=2, N_OUT=3)
module tb_dnn_fc_layer_fix;
  localparam int DW = 12;
  localparam int NI = 2;
  localparam int NO = 3;
  localparam int LAT = NO * (2 * NI + 5);

  typedef struct {
    int a0, a1;
    int w00, w01, w02, w10, w11, w12, w20, w21, w22;
    int e0, e1, e2, cls;
  } vec_t;

  typedef struct {
    int e0, e1, e2, cls;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst, start, clear;
  logic signed [DW-1:0] mem_data;
  logic [15:0]          mem_addr;
  logic                 done;
  logic signed [DW-1:0] out [NO];
  logic [1:0]           class_idx;

  logic signed [DW-1:0] mem [0:65535];
  int                   trace [0:127];
  exp_t                 sb [$];
  vec_t                 vt [5];
  int                   n_cmp = 0;
  int                   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  dnn_fc_layer_fix #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .mem_data(mem_data), .mem_addr(mem_addr), .done(done),
    .out(out), .class_idx(class_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fdiv(input int p);
    if (p >= 0) return p / 1024;
    return -((-p + 1023) / 1024);
  endfunction

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   e [3];
    r    = v;
    e[0] = sat(fdiv(v.a0 * v.w00) + fdiv(v.a1 * v.w01) + fdiv(1024 * v.w02));
    e[1] = sat(fdiv(v.a0 * v.w10) + fdiv(v.a1 * v.w11) + fdiv(1024 * v.w12));
    e[2] = sat(fdiv(v.a0 * v.w20) + fdiv(v.a1 * v.w21) + fdiv(1024 * v.w22));
    r.cls = 0;
    for (int j = 1; j < 3; j++) if (e[j] > e[r.cls]) r.cls = j;
    r.e0 = e[0];
    r.e1 = e[1];
    r.e2 = e[2];
    return r;
  endfunction

  task automatic load(input vec_t v);
    mem[0]         = DW'(v.a0);
    mem[1]         = DW'(v.a1);
    mem[2]         = DW'(777);
    mem[16'h191]   = DW'(v.w00);
    mem[16'h192]   = DW'(v.w01);
    mem[16'h193]   = DW'(v.w02);
    mem[16'h194]   = DW'(v.w10);
    mem[16'h195]   = DW'(v.w11);
    mem[16'h196]   = DW'(v.w12);
    mem[16'h197]   = DW'(v.w20);
    mem[16'h198]   = DW'(v.w21);
    mem[16'h199]   = DW'(v.w22);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.e0  = v.e0;
    e.e1  = v.e1;
    e.e2  = v.e2;
    e.cls = v.cls;
    sb.push_back(e);
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 120) begin
      trace[cyc] = int'(mem_addr);
      tick();
      cyc++;
    end
  endtask

  task automatic check_results(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_out0"}, int'(out[0]), e.e0);
      check({tag, "_out1"}, int'(out[1]), e.e1);
      check({tag, "_out2"}, int'(out[2]), e.e2);
      check({tag, "_class"}, int'(class_idx), e.cls);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_out0"}, int'(out[0]), 0);
    check({tag, "_out1"}, int'(out[1]), 0);
    check({tag, "_out2"}, int'(out[2]), 0);
    check({tag, "_class"}, int'(class_idx), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    vec_t v;
    int   tr_n0 [6] = '{0, 'h191, 1, 'h192, 2, 'h193};
    int   tr_n1 [6] = '{0, 'h194, 1, 'h195, 2, 'h196};

    vt[0] = '{512, 1024, 1024, 1024, 0, 2047, 2047, 2047, -2048, -2048, -2048, 1536, 2047, -2048, 1};
    vt[1] = '{512, 1024, 1024, 0, 0, 1024, 0, 0, 1024, 0, 0, 512, 512, 512, 0};
    vt[2] = '{1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 1};
    vt[3] = '{512, 1024, 0, 0, -1024, 1024, 0, 512, 0, 1024, 0, -1024, 1024, 1024, 1};
    vt[4] = '{-512, 1024, 1024, 0, 0, -1024, 0, 0, 0, 1024, 1, -512, 512, 1025, 2};

    for (int k = 0; k < 65536; k++) mem[k] = '0;
    for (int k = 0; k < 4096; k++) mem[16'h29be + k] = DW'(k - 2048);

    rst = 1'b0; clear = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      load(vt[k]);
      push_exp(vt[k]);
      launch();
      wait_done(cyc);
      check($sformatf("vec%0d_latency", k), cyc, LAT);
      check_results($sformatf("vec%0d", k));
      if (k == 0) begin
        for (int t = 0; t < 6; t++) begin
          check($sformatf("trace_n0_%0d", t), trace[t], tr_n0[t]);
          check($sformatf("trace_n1_%0d", t), trace[9 + t], tr_n1[t]);
        end
        check("trace_lut0", trace[7], 'h29be + 'hE00);
        check("trace_lut1", trace[16], 'h29be + 'hFFF);
        check("trace_lut2", trace[25], 'h29be);
      end
    end

    for (int k = 0; k < 3; k++) begin
      v.a0  = int'($urandom_range(4095)) - 2048;
      v.a1  = int'($urandom_range(4095)) - 2048;
      v.w00 = int'($urandom_range(4095)) - 2048;
      v.w01 = int'($urandom_range(4095)) - 2048;
      v.w02 = int'($urandom_range(511)) - 256;
      v.w10 = int'($urandom_range(4095)) - 2048;
      v.w11 = int'($urandom_range(4095)) - 2048;
      v.w12 = int'($urandom_range(511)) - 256;
      v.w20 = int'($urandom_range(511)) - 256;
      v.w21 = int'($urandom_range(511)) - 256;
      v.w22 = int'($urandom_range(4095)) - 2048;
      v = model(v);
      load(v);
      push_exp(v);
      launch();
      wait_done(cyc);
      check($sformatf("rand%0d_latency", k), cyc, LAT);
      check_results($sformatf("rand%0d", k));
    end

    for (int m = 0; m < 2; m++) begin
      load(vt[0]);
      launch();
      for (int c = 0; c < 10; c++) tick();
      check($sformatf("abort%0d_pre_out0", m), int'(out[0]), 1536);
      if (m == 0) clear = 1'b1;
      else rst = 1'b0;
      tick();
      clear = 1'b0;
      rst = 1'b1;
      check_idle($sformatf("abort%0d", m));
      push_exp(vt[0]);
      launch();
      wait_done(cyc);
      check($sformatf("abort%0d_latency", m), cyc, LAT);
      check_results($sformatf("abort%0d_rerun", m));
    end

    load(vt[3]);
    start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      push_exp(vt[3]);
      wait_done(cyc);
      check($sformatf("hold%0d_latency", r), cyc, LAT);
      check_results($sformatf("hold%0d", r));
      if (r < 2) begin
        tick();
        check($sformatf("hold%0d_done_pulse", r), int'(done), 0);
        check($sformatf("hold%0d_restart_addr", r), int'(mem_addr), 0);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check_idle("clear_over_start");
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
